// File: rtl/abs_diff_accum_if.sv
// Pixel-pair stream in, block SAD out: the two valid/ready channels of abs_diff_accum.
// The master drives pixel pairs and consumes the SAD; the slave is the accumulator.
interface abs_diff_accum_if #(
  parameter int PIX_WIDTH = 8,
  parameter int BIT_WIDTH = 14
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_WIDTH-1:0] cur_pix;
  logic [PIX_WIDTH-1:0] ref_pix;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] sad;
  logic                 sat;

  modport master (
    output in_valid, cur_pix, ref_pix, out_ready,
    input  in_ready, out_valid, sad, sat
  );

  modport slave (
    input  in_valid, cur_pix, ref_pix, out_ready,
    output in_ready, out_valid, sad, sat
  );
endinterface

// File: rtl/abs_diff_accum.sv
// Block sum of absolute differences: |cur - ref| registered per pair, then a
// saturating accumulate over BLOCK_PIXELS pairs, result held until accepted.
module abs_diff_accum #(
  parameter int PIX_WIDTH    = 8,
  parameter int BIT_WIDTH    = 14,
  parameter int BLOCK_PIXELS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_clr,
  abs_diff_accum_if.slave    bus
);
  localparam int CW = $clog2(BLOCK_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        in_cnt, acc_cnt;
  logic [PIX_WIDTH-1:0] diff_p1;
  logic                 vld_p1;
  logic [BIT_WIDTH-1:0] acc, sad_q;
  logic                 sat_q, out_valid_q;
  logic                 xfer, last_beat;
  logic [BIT_WIDTH:0]   sum_p1;

  function automatic logic [PIX_WIDTH-1:0] abs_diff(input logic [PIX_WIDTH-1:0] a,
                                                    input logic [PIX_WIDTH-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // The extra carry bit marks overflow; clamp to all-ones.
  function automatic logic [BIT_WIDTH-1:0] sat_clamp(input logic [BIT_WIDTH:0] s);
    return s[BIT_WIDTH] ? {BIT_WIDTH{1'b1}} : s[BIT_WIDTH-1:0];
  endfunction

  assign bus.in_ready  = (state != DONE) && (in_cnt < CW'(BLOCK_PIXELS));
  assign bus.out_valid = out_valid_q;
  assign bus.sad       = sad_q;
  assign bus.sat       = sat_q;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign sum_p1    = {1'b0, acc} + {{(BIT_WIDTH + 1 - PIX_WIDTH){1'b0}}, diff_p1};
  assign last_beat = vld_p1 && (acc_cnt == CW'(BLOCK_PIXELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer)          state_nxt = ACCUM;
      ACCUM:   if (last_beat)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
    if (blk_clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt      <= '0;
      acc_cnt     <= '0;
      acc         <= '0;
      diff_p1     <= '0;
      vld_p1      <= 1'b0;
      sad_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (blk_clr) begin
      in_cnt      <= '0;
      acc_cnt     <= '0;
      acc         <= '0;
      vld_p1      <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // stage 1: absolute difference of the accepted pair
      vld_p1 <= xfer;
      if (xfer) begin
        diff_p1 <= abs_diff(bus.cur_pix, bus.ref_pix);
        in_cnt  <= in_cnt + 1'b1;
      end
      // stage 2: saturating accumulate, or hand-off of the finished block
      if (state == DONE) begin
        if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          acc         <= '0;
          in_cnt      <= '0;
          acc_cnt     <= '0;
          sat_q       <= 1'b0;
        end
      end else if (vld_p1) begin
        acc     <= sat_clamp(sum_p1);
        acc_cnt <= acc_cnt + 1'b1;
        if (sum_p1[BIT_WIDTH]) sat_q <= 1'b1;
        if (last_beat) begin
          sad_q       <= sat_clamp(sum_p1);
          out_valid_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_abs_diff_accum.sv
// Directed bench for abs_diff_accum: a 4-pixel block instance for protocol cases
// and two 64-pixel instances (14- and 12-bit) for the saturation boundary.
module tb_abs_diff_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr4 = 1'b0, clr64 = 1'b0, clr12 = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  abs_diff_accum_if #(.PIX_WIDTH(8), .BIT_WIDTH(14)) b4  ();
  abs_diff_accum_if #(.PIX_WIDTH(8), .BIT_WIDTH(14)) b64 ();
  abs_diff_accum_if #(.PIX_WIDTH(8), .BIT_WIDTH(12)) b12 ();

  abs_diff_accum #(.PIX_WIDTH(8), .BIT_WIDTH(14), .BLOCK_PIXELS(4))
    u4  (.clk(clk), .rst_n(rst_n), .blk_clr(clr4),  .bus(b4));
  abs_diff_accum #(.PIX_WIDTH(8), .BIT_WIDTH(14), .BLOCK_PIXELS(64))
    u64 (.clk(clk), .rst_n(rst_n), .blk_clr(clr64), .bus(b64));
  abs_diff_accum #(.PIX_WIDTH(8), .BIT_WIDTH(12), .BLOCK_PIXELS(64))
    u12 (.clk(clk), .rst_n(rst_n), .blk_clr(clr12), .bus(b12));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [7:0] c, input logic [7:0] r);
    b4.in_valid = 1'b1;
    b4.cur_pix  = c;
    b4.ref_pix  = r;
    step();
    b4.in_valid = 1'b0;
  endtask

  task automatic accept4();
    b4.out_ready = 1'b1;
    step();
    b4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    nvec++; if (b4.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", b4.out_valid); end
    nvec++; if (b4.sad !== 14'd0) begin nerr++; $display("FAIL reset_sad got %0d want 0", b4.sad); end
    nvec++; if (b4.sat !== 1'b0) begin nerr++; $display("FAIL reset_sat got %b want 0", b4.sat); end
    nvec++; if (b12.sad !== 12'd0 || b12.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_b12 got sad=%0d ov=%b want 0/0", b12.sad, b12.out_valid); end
    #3 rst_n = 1'b1;
    step();
    nvec++; if (b4.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", b4.in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] cs [4] = '{8'd10, 8'd3,  8'd200, 8'd0};
    logic [7:0] rs [4] = '{8'd3,  8'd10, 8'd200, 8'd255};
    for (int i = 0; i < 4; i++) drive4(cs[i], rs[i]);
    nvec++; if (b4.out_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %b want 0", b4.out_valid); end
    step();
    nvec++; if (b4.out_valid !== 1'b1) begin nerr++; $display("FAIL basic_out_valid got %b want 1", b4.out_valid); end
    nvec++; if (b4.sad !== 14'd269) begin nerr++; $display("FAIL basic_sad got %0d want 269", b4.sad); end
    nvec++; if (b4.sat !== 1'b0) begin nerr++; $display("FAIL basic_sat got %b want 0", b4.sat); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      nvec++; if (b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1 || b4.sad !== 14'd269) begin
        nerr++; $display("FAIL hold_cycle%0d got in_ready=%b ov=%b sad=%0d want 0/1/269", i, b4.in_ready, b4.out_valid, b4.sad);
      end
      step();
    end
    accept4();
    nvec++; if (b4.out_valid !== 1'b0) begin nerr++; $display("FAIL hold_release_valid got %b want 0", b4.out_valid); end
    nvec++; if (b4.in_ready !== 1'b1) begin nerr++; $display("FAIL hold_release_ready got %b want 1", b4.in_ready); end
    for (int i = 0; i < 4; i++) drive4(8'd2, 8'd0);
    step();
    nvec++; if (b4.out_valid !== 1'b1 || b4.sad !== 14'd8) begin nerr++; $display("FAIL hold_next_block got ov=%b sad=%0d want 1/8", b4.out_valid, b4.sad); end
    accept4();
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 4; i++) begin
      drive4(8'd5, 8'd1);
      step();
      step();
      if (i < 3) begin
        nvec++; if (b4.out_valid !== 1'b0) begin nerr++; $display("FAIL gap_early_valid%0d got %b want 0", i, b4.out_valid); end
      end
    end
    nvec++; if (b4.out_valid !== 1'b1 || b4.sad !== 14'd16) begin nerr++; $display("FAIL gap_sad got ov=%b sad=%0d want 1/16", b4.out_valid, b4.sad); end
    accept4();
    for (int i = 0; i < 4; i++) begin
      nvec++; if (b4.out_valid !== 1'b0) begin nerr++; $display("FAIL gap_extra_valid%0d got %b want 0", i, b4.out_valid); end
      step();
    end
  endtask

  task automatic test_blk_clr();
    drive4(8'd9, 8'd1);
    drive4(8'd9, 8'd1);
    clr4 = 1'b1;
    drive4(8'd9, 8'd1);
    clr4 = 1'b0;
    nvec++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin nerr++; $display("FAIL clr_state got in_ready=%b ov=%b want 1/0", b4.in_ready, b4.out_valid); end
    for (int i = 0; i < 4; i++) drive4(8'd1, 8'd0);
    step();
    nvec++; if (b4.out_valid !== 1'b1 || b4.sad !== 14'd4) begin nerr++; $display("FAIL clr_sad got ov=%b sad=%0d want 1/4", b4.out_valid, b4.sad); end
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    nvec++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin nerr++; $display("FAIL clr_pending got ov=%b in_ready=%b want 0/1", b4.out_valid, b4.in_ready); end
  endtask

  task automatic test_saturation();
    b64.cur_pix = 8'd255; b64.ref_pix = 8'd0;
    b12.cur_pix = 8'd255; b12.ref_pix = 8'd0;
    b64.in_valid = 1'b1; b12.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) step();
    b64.in_valid = 1'b0; b12.in_valid = 1'b0;
    nvec++; if (b64.in_ready !== 1'b0) begin nerr++; $display("FAIL sat_full_ready got %b want 0", b64.in_ready); end
    step();
    nvec++; if (b64.out_valid !== 1'b1 || b64.sad !== 14'd16320 || b64.sat !== 1'b0) begin
      nerr++; $display("FAIL sat_14bit got ov=%b sad=%0d sat=%b want 1/16320/0", b64.out_valid, b64.sad, b64.sat);
    end
    nvec++; if (b12.out_valid !== 1'b1 || b12.sad !== 12'd4095 || b12.sat !== 1'b1) begin
      nerr++; $display("FAIL sat_12bit got ov=%b sad=%0d sat=%b want 1/4095/1", b12.out_valid, b12.sad, b12.sat);
    end
    b64.out_ready = 1'b1; b12.out_ready = 1'b1;
    step();
    b64.out_ready = 1'b0; b12.out_ready = 1'b0;
    nvec++; if (b12.sat !== 1'b0 || b12.out_valid !== 1'b0) begin nerr++; $display("FAIL sat_clear got sat=%b ov=%b want 0/0", b12.sat, b12.out_valid); end
  endtask

  task automatic test_async_reset();
    drive4(8'd1, 8'd0);
    drive4(8'd1, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (b4.sad !== 14'd0 || b4.out_valid !== 1'b0 || b4.sat !== 1'b0) begin
      nerr++; $display("FAIL arst_mid got sad=%0d ov=%b sat=%b want 0/0/0", b4.sad, b4.out_valid, b4.sat);
    end
    #1 rst_n = 1'b1;
    step();
    nvec++; if (b4.in_ready !== 1'b1) begin nerr++; $display("FAIL arst_mid_ready got %b want 1", b4.in_ready); end
    for (int i = 0; i < 4; i++) drive4(8'd0, 8'd3);
    step();
    nvec++; if (b4.out_valid !== 1'b1 || b4.sad !== 14'd12) begin nerr++; $display("FAIL arst_block got ov=%b sad=%0d want 1/12", b4.out_valid, b4.sad); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (b4.sad !== 14'd0 || b4.out_valid !== 1'b0) begin nerr++; $display("FAIL arst_done got sad=%0d ov=%b want 0/0", b4.sad, b4.out_valid); end
    #1 rst_n = 1'b1;
    step();
    nvec++; if (b4.in_ready !== 1'b1) begin nerr++; $display("FAIL arst_done_ready got %b want 1", b4.in_ready); end
    for (int i = 0; i < 4; i++) drive4(8'd10, 8'd3);
    step();
    nvec++; if (b4.out_valid !== 1'b1 || b4.sad !== 14'd28) begin nerr++; $display("FAIL arst_after got ov=%b sad=%0d want 1/28", b4.out_valid, b4.sad); end
    accept4();
  endtask

  initial begin
    b4.in_valid  = 1'b0; b4.cur_pix  = '0; b4.ref_pix  = '0; b4.out_ready  = 1'b0;
    b64.in_valid = 1'b0; b64.cur_pix = '0; b64.ref_pix = '0; b64.out_ready = 1'b0;
    b12.in_valid = 1'b0; b12.cur_pix = '0; b12.ref_pix = '0; b12.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_gapped();
    test_blk_clr();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
